// File: rtl/row_write_arbiter.sv
// row_write_arbiter
// Arbitrates row writes from two sources (USB and diagnostic) into a single
// controller row-buffer write port. A source wins a frame lock by writing
// row 0 / panel 0 and keeps it until it writes row 15 / panel 3. Ties at frame
// start are resolved round-robin, with USB favoured after reset.
//
// Optional feature: define ARB_TIMEOUT_EN to release a lock after
// TIMEOUT_CYCLES cycles without an accepted write from the lock owner.
//
// Ports
//   clk, reset_n                    system clock, async active-low reset
//   usb_req/_row_data/_row_addr/_panel_addr, usb_ack    USB source
//   diag_req/_row_data/_row_addr/_panel_addr, diag_ack  diagnostic source
//   row_data, row_data_row_addr, row_data_panel_addr    registered payload
//   row_data_write_enable           one-cycle write strobe (OR of the acks)
//   owner                           00 none, 01 USB, 10 diag
//   frame_done                      pulse on the strobe that ends a frame
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no lock; only row 0 / panel 0 requests are granted
// LOCK_USB  | USB owns the frame; diag requests wait unacknowledged
// LOCK_DIAG | diag owns the frame; USB requests wait unacknowledged
module row_write_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         usb_req,
  input  logic [383:0] usb_row_data,
  input  logic [3:0]   usb_row_addr,
  input  logic [1:0]   usb_panel_addr,
  output logic         usb_ack,
  input  logic         diag_req,
  input  logic [383:0] diag_row_data,
  input  logic [3:0]   diag_row_addr,
  input  logic [1:0]   diag_panel_addr,
  output logic         diag_ack,
  output logic [383:0] row_data,
  output logic [3:0]   row_data_row_addr,
  output logic [1:0]   row_data_panel_addr,
  output logic         row_data_write_enable,
  output logic [1:0]   owner,
  output logic         frame_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOCK_USB  = 2'b01,
    LOCK_DIAG = 2'b10
  } state_t;

  state_t state;
  logic   rr_diag;   // set when diag should win the next frame-start tie

  logic         usb_start;
  logic         diag_start;
  logic         busy;
  logic         grant_usb;
  logic         grant_diag;
  logic         grant_any;
  logic         last_write;
  logic [383:0] sel_data;
  logic [3:0]   sel_row;
  logic [1:0]   sel_panel;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign owner      = state;
  assign usb_start  = usb_req && (usb_row_addr == 4'd0) && (usb_panel_addr == 2'd0);
  assign diag_start = diag_req && (diag_row_addr == 4'd0) && (diag_panel_addr == 2'd0);
  // A source still holds req during its ack cycle; that cycle is never sampled.
  assign busy       = usb_ack || diag_ack;

  always_comb begin
    grant_usb  = 1'b0;
    grant_diag = 1'b0;
    if (!busy) begin
      case (state)
        IDLE: begin
          if (usb_start && diag_start) begin
            grant_diag = rr_diag;
            grant_usb  = !rr_diag;
          end else begin
            grant_usb  = usb_start;
            grant_diag = diag_start;
          end
        end
        LOCK_USB:  grant_usb  = usb_req;
        LOCK_DIAG: grant_diag = diag_req;
        default: ;
      endcase
    end
  end

  assign grant_any  = grant_usb || grant_diag;
  assign sel_data   = grant_usb ? usb_row_data   : diag_row_data;
  assign sel_row    = grant_usb ? usb_row_addr   : diag_row_addr;
  assign sel_panel  = grant_usb ? usb_panel_addr : diag_panel_addr;
  assign last_write = (sel_row == 4'd15) && (sel_panel == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      rr_diag               <= 1'b0;
      usb_ack               <= 1'b0;
      diag_ack              <= 1'b0;
      row_data_write_enable <= 1'b0;
      frame_done            <= 1'b0;
      row_data              <= '0;
      row_data_row_addr     <= '0;
      row_data_panel_addr   <= '0;
`ifdef ARB_TIMEOUT_EN
      idle_cnt              <= '0;
`endif
    end else begin
      usb_ack               <= grant_usb;
      diag_ack              <= grant_diag;
      row_data_write_enable <= grant_any;
      frame_done            <= 1'b0;
      if (grant_any) begin
        row_data            <= sel_data;
        row_data_row_addr   <= sel_row;
        row_data_panel_addr <= sel_panel;
      end

      case (state)
        IDLE: begin
          if (grant_usb) begin
            state   <= LOCK_USB;
            rr_diag <= 1'b1;
          end else if (grant_diag) begin
            state   <= LOCK_DIAG;
            rr_diag <= 1'b0;
          end
        end
        default: begin
          // The lock is kept through the final strobe and dropped one cycle later.
          if (frame_done) begin
            state <= IDLE;
          end else if (grant_any && last_write) begin
            frame_done <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (!grant_any && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state <= IDLE;
          end
`endif
        end
      endcase

`ifdef ARB_TIMEOUT_EN
      if ((state == IDLE) || grant_any || frame_done ||
          (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_row_write_arbiter.sv
// Testbench for row_write_arbiter: directed vector table, hand-written
// frame/reset/timeout sequences, and randomized traffic against a
// behavioural model.
module tb_row_write_arbiter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         usb_req = 1'b0;
  logic [383:0] usb_row_data = '0;
  logic [3:0]   usb_row_addr = '0;
  logic [1:0]   usb_panel_addr = '0;
  logic         usb_ack;
  logic         diag_req = 1'b0;
  logic [383:0] diag_row_data = '0;
  logic [3:0]   diag_row_addr = '0;
  logic [1:0]   diag_panel_addr = '0;
  logic         diag_ack;
  logic [383:0] row_data;
  logic [3:0]   row_data_row_addr;
  logic [1:0]   row_data_panel_addr;
  logic         row_data_write_enable;
  logic [1:0]   owner;
  logic         frame_done;

  int n_vec = 0;
  int n_err = 0;

  row_write_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .usb_req              (usb_req),
    .usb_row_data         (usb_row_data),
    .usb_row_addr         (usb_row_addr),
    .usb_panel_addr       (usb_panel_addr),
    .usb_ack              (usb_ack),
    .diag_req             (diag_req),
    .diag_row_data        (diag_row_data),
    .diag_row_addr        (diag_row_addr),
    .diag_panel_addr      (diag_panel_addr),
    .diag_ack             (diag_ack),
    .row_data             (row_data),
    .row_data_row_addr    (row_data_row_addr),
    .row_data_panel_addr  (row_data_panel_addr),
    .row_data_write_enable(row_data_write_enable),
    .owner                (owner),
    .frame_done           (frame_done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [383:0] mkdata(input bit d, input logic [3:0] r, input logic [1:0] p);
    logic [31:0] w;
    w = {(d ? 8'hD1 : 8'hB5), 16'h5A00, 2'b00, p, r};
    return {12{w}};
  endfunction

  task automatic set_src(input bit d, input logic req, input logic [3:0] r,
                         input logic [1:0] p, input logic [383:0] data);
    if (d) begin
      diag_req = req; diag_row_addr = r; diag_panel_addr = p; diag_row_data = data;
    end else begin
      usb_req = req; usb_row_addr = r; usb_panel_addr = p; usb_row_data = data;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_src(0, 0, 0, 0, '0);
    set_src(1, 0, 0, 0, '0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {usb_ack, diag_ack, row_data_write_enable, frame_done, owner}, 6'b0);
    chk("reset_addr", {row_data_row_addr, row_data_panel_addr}, 6'b0);
    chk("reset_data", row_data, '0);
    reset_n = 1'b1;
  endtask

  // Issues one write, waits for its ack, checks the strobe, then drops req and
  // checks that the ack was a single-cycle pulse.
  task automatic write_one(input bit d, input logic [3:0] r, input logic [1:0] p,
                           output int lat, output logic fd, output logic [1:0] own);
    logic ackd;
    lat = 0;
    set_src(d, 1, r, p, mkdata(d, r, p));
    do begin
      tick();
      lat++;
      ackd = d ? diag_ack : usb_ack;
    end while (!ackd && lat < 200);
    chk("ack_wait", ackd, 1'b1);
    fd  = frame_done;
    own = owner;
    chk("strobe", {row_data_write_enable, (d ? usb_ack : diag_ack)}, 2'b10);
    chk("strobe_addr", {row_data_row_addr, row_data_panel_addr}, {r, p});
    chk("strobe_data", row_data, mkdata(d, r, p));
    set_src(d, 0, r, p, mkdata(d, r, p));
    tick();
    chk("ack_pulse", {usb_ack, diag_ack, row_data_write_enable}, 3'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       u_req; logic [3:0] u_row; logic [1:0] u_pan;
    logic       d_req; logic [3:0] d_row; logic [1:0] d_pan;
    logic       e_uack; logic e_dack; logic [1:0] e_owner; logic e_fd;
    logic [3:0] e_row; logic [1:0] e_pan;
  } vec_t;

  vec_t vt[17];

  task automatic run_table();
    logic [383:0] held;
    vt[0]  = '{1, 0, 0, 1, 0, 0,   1, 0, 2'b01, 0,  0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 0,   0, 0, 2'b01, 0,  0, 0};
    vt[2]  = '{1, 15, 3, 1, 0, 0,  1, 0, 2'b01, 1, 15, 3};
    vt[3]  = '{0, 0, 0, 1, 0, 0,   0, 0, 2'b00, 0, 15, 3};
    vt[4]  = '{0, 0, 0, 1, 0, 0,   0, 1, 2'b10, 0,  0, 0};
    vt[5]  = '{1, 0, 0, 1, 0, 0,   0, 0, 2'b10, 0,  0, 0};
    vt[6]  = '{1, 0, 0, 1, 15, 3,  0, 1, 2'b10, 1, 15, 3};
    vt[7]  = '{1, 0, 0, 0, 0, 0,   0, 0, 2'b00, 0, 15, 3};
    vt[8]  = '{1, 0, 0, 1, 0, 0,   1, 0, 2'b01, 0,  0, 0};
    vt[9]  = '{1, 7, 1, 1, 0, 0,   0, 0, 2'b01, 0,  0, 0};
    vt[10] = '{1, 7, 1, 1, 0, 0,   1, 0, 2'b01, 0,  7, 1};
    vt[11] = '{1, 15, 3, 1, 0, 0,  0, 0, 2'b01, 0,  7, 1};
    vt[12] = '{1, 15, 3, 1, 0, 0,  1, 0, 2'b01, 1, 15, 3};
    vt[13] = '{1, 0, 0, 1, 0, 0,   0, 0, 2'b00, 0, 15, 3};
    vt[14] = '{1, 0, 0, 1, 0, 0,   0, 1, 2'b10, 0,  0, 0};
    vt[15] = '{0, 0, 0, 1, 3, 2,   0, 0, 2'b10, 0,  0, 0};
    vt[16] = '{0, 0, 0, 1, 3, 2,   0, 1, 2'b10, 0,  3, 2};
    do_reset();
    held = '0;
    for (int i = 0; i < 17; i++) begin
      set_src(0, vt[i].u_req, vt[i].u_row, vt[i].u_pan, mkdata(0, vt[i].u_row, vt[i].u_pan));
      set_src(1, vt[i].d_req, vt[i].d_row, vt[i].d_pan, mkdata(1, vt[i].d_row, vt[i].d_pan));
      if (vt[i].e_uack) held = mkdata(0, vt[i].u_row, vt[i].u_pan);
      if (vt[i].e_dack) held = mkdata(1, vt[i].d_row, vt[i].d_pan);
      tick();
      chk($sformatf("tbl%0d_ctrl", i),
          {usb_ack, diag_ack, row_data_write_enable, frame_done, owner},
          {vt[i].e_uack, vt[i].e_dack, vt[i].e_uack | vt[i].e_dack, vt[i].e_fd, vt[i].e_owner});
      chk($sformatf("tbl%0d_addr", i), {row_data_row_addr, row_data_panel_addr},
          {vt[i].e_row, vt[i].e_pan});
      chk($sformatf("tbl%0d_data", i), row_data, held);
    end
  endtask

  // ---------------- behavioural model for random traffic ----------------
  int           m_lock;      // 0 none, 1 USB, 2 diag
  bit           m_rr_diag;
  bit           m_ack_u, m_ack_d, m_fd;
  logic [3:0]   m_row;
  logic [1:0]   m_pan;
  logic [383:0] m_data;
  int           m_idle;

  task automatic model_reset();
    m_lock = 0; m_rr_diag = 0; m_ack_u = 0; m_ack_d = 0; m_fd = 0;
    m_row = '0; m_pan = '0; m_data = '0; m_idle = 0;
  endtask

  // Given this cycle's inputs, produce the expected outputs of the next cycle.
  task automatic model_step();
    bit u_fs, d_fs, take_u, take_d, next_fd;
    take_u = 0; take_d = 0;
    u_fs = usb_req && usb_row_addr == 4'd0 && usb_panel_addr == 2'd0;
    d_fs = diag_req && diag_row_addr == 4'd0 && diag_panel_addr == 2'd0;
    if (!m_ack_u && !m_ack_d) begin
      if (m_lock == 0) begin
        if (u_fs && d_fs) begin
          if (m_rr_diag) take_d = 1; else take_u = 1;
        end else begin
          take_u = u_fs; take_d = d_fs;
        end
      end else if (m_lock == 1) take_u = usb_req;
      else take_d = diag_req;
    end
    if (take_u) begin m_row = usb_row_addr; m_pan = usb_panel_addr; m_data = usb_row_data; end
    if (take_d) begin m_row = diag_row_addr; m_pan = diag_panel_addr; m_data = diag_row_data; end
    next_fd = (m_lock != 0) && (take_u || take_d) && m_row == 4'd15 && m_pan == 2'd3;
    if (m_lock != 0 && m_fd) begin
      m_lock = 0; m_idle = 0;
    end else if (m_lock == 0) begin
      m_idle = 0;
      if (take_u) begin m_lock = 1; m_rr_diag = 1; end
      if (take_d) begin m_lock = 2; m_rr_diag = 0; end
    end else if (take_u || take_d) begin
      m_idle = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin m_lock = 0; m_idle = 0; end
`endif
    end
    m_ack_u = take_u; m_ack_d = take_d; m_fd = next_fd;
  endtask

  task automatic rnd_req(input bit d);
    logic [383:0] data;
    int k;
    for (int i = 0; i < 12; i++) data[i*32 +: 32] = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      set_src(d, 1, 4'd0, 2'd0, data);
    else if (k < 6) set_src(d, 1, 4'd15, 2'd3, data);
    else            set_src(d, 1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), data);
  endtask

  task automatic run_random(input int cycles);
    int wait_u, wait_d;
    wait_u = 0; wait_d = 0;
    do_reset();
    model_reset();
    model_step();
    for (int c = 0; c < cycles; c++) begin
      tick();
      chk("rnd_ctrl", {usb_ack, diag_ack, row_data_write_enable, frame_done, owner},
          {m_ack_u, m_ack_d, m_ack_u | m_ack_d, m_fd, (m_lock == 1) ? 2'b01 : (m_lock == 2) ? 2'b10 : 2'b00});
      chk("rnd_addr", {row_data_row_addr, row_data_panel_addr}, {m_row, m_pan});
      chk("rnd_data", row_data, m_data);
      if (m_ack_u) begin
        usb_req = 0; wait_u = 0;
        if ($urandom_range(0, 2) == 0) rnd_req(0);
      end else if (!usb_req) begin
        if ($urandom_range(0, 3) == 0) rnd_req(0);
      end else begin
        wait_u++;
        if (wait_u > 6 && $urandom_range(0, 3) == 0) begin rnd_req(0); wait_u = 0; end
      end
      if (m_ack_d) begin
        diag_req = 0; wait_d = 0;
        if ($urandom_range(0, 2) == 0) rnd_req(1);
      end else if (!diag_req) begin
        if ($urandom_range(0, 3) == 0) rnd_req(1);
      end else begin
        wait_d++;
        if (wait_d > 6 && $urandom_range(0, 3) == 0) begin rnd_req(1); wait_d = 0; end
      end
      model_step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic fd;
    logic [1:0] own;
    bit ok;
    int t;

    run_table();

    // Full USB frame, panel-major order; frame_done only on the last write.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        write_one(0, 4'(r), 2'(p), lat, fd, own);
        chk($sformatf("frame_p%0d_r%0d", p, r), {32'(lat), fd, own},
            {32'd1, (r == 15 && p == 3) ? 1'b1 : 1'b0, 2'b01});
      end
    end
    chk("frame_release", owner, 2'b00);

    // Diag not at frame start is held off, then granted once it asks for 0/0.
    do_reset();
    set_src(1, 1, 4'd5, 2'd2, mkdata(1, 5, 2));
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (diag_ack || usb_ack || owner != 2'b00) ok = 0;
    end
    chk("nonstart_held", ok, 1'b1);
    set_src(1, 1, 4'd0, 2'd0, mkdata(1, 0, 0));
    tick();
    chk("nonstart_then_grant", {diag_ack, owner}, {1'b1, 2'b10});

    // Reset mid-frame clears everything asynchronously; diag wins afterwards.
    do_reset();
    for (int r = 0; r < 10; r++) write_one(0, 4'(r), 2'd0, lat, fd, own);
    set_src(0, 1, 4'd10, 2'd0, mkdata(0, 10, 0));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {usb_ack, diag_ack, row_data_write_enable, frame_done, owner}, 6'b0);
    chk("async_rst_addr", {row_data_row_addr, row_data_panel_addr}, 6'b0);
    chk("async_rst_data", row_data, '0);
    @(negedge clk);
    set_src(0, 0, 0, 0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    write_one(1, 4'd0, 2'd0, lat, fd, own);
    chk("post_rst_diag", {32'(lat), own}, {32'd1, 2'b10});

    // Silent lock owner with a pending diag frame start.
    do_reset();
    write_one(0, 4'd0, 2'd0, lat, fd, own);
    set_src(1, 1, 4'd0, 2'd0, mkdata(1, 0, 0));
`ifdef ARB_TIMEOUT_EN
    t = 1;
    ok = 1;
    while (owner != 2'b00 && t < 300) begin
      tick();
      t++;
      if (frame_done || diag_ack) ok = 0;
    end
    chk("timeout_cycles", t, TO);
    chk("timeout_no_fd", ok, 1'b1);
    tick();
    chk("timeout_diag_grant", {diag_ack, owner}, {1'b1, 2'b10});
`else
    ok = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (owner != 2'b01 || diag_ack || frame_done) ok = 0;
    end
    chk("lock_persists", ok, 1'b1);
`endif

    run_random(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/row_write_arbiter.md
ROW_WRITE_ARBITER -- requirements
Module: row_write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: idle cycles after which a frame lock is released (only with ARB_TIMEOUT_EN).
REQ-002 clk  input  1  system clock (50 MHz); all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 usb_req  input  1  USB source write request; held high until usb_ack.
REQ-005 usb_row_data  input  384  USB row payload; stable while usb_req high.
REQ-006 usb_row_addr  input  4  USB row address.
REQ-007 usb_panel_addr  input  2  USB panel address.
REQ-008 usb_ack  output  1  one-cycle acceptance pulse to USB source.
REQ-009 diag_req, diag_row_data[383:0], diag_row_addr[3:0], diag_panel_addr[1:0], diag_ack: the same set for the diagnostic source.
REQ-010 row_data  output  384  payload to the controller row buffer.
REQ-011 row_data_row_addr  output  4  row address to the controller.
REQ-012 row_data_panel_addr  output  2  panel address to the controller.
REQ-013 row_data_write_enable  output  1  one-cycle write strobe.
REQ-014 owner  output  2  lock status: 00 none, 01 USB, 10 diag.
REQ-015 frame_done  output  1  one-cycle pulse when a locked frame completes.

Function
REQ-016 FSM states IDLE, LOCK_USB, LOCK_DIAG; owner encodes the state.
REQ-017 IDLE: a request is granted only when it addresses row 0, panel 0 (frame start); the granted source's lock state is entered in the same cycle the write is accepted.
REQ-018 IDLE, both sources requesting a frame start: round-robin; the source that did not own the last lock wins; after reset USB wins.
REQ-019 IDLE, a request not at row 0/panel 0: the request is held unacknowledged and the FSM does not lock.
REQ-020 LOCK_x: only source x is sampled; the other source's requests stay pending with no ack.
REQ-021 Acceptance: in the cycle after a sampled req, the FSM registers data/addresses to the outputs, pulses row_data_write_enable and the source's ack together (latency 1).
REQ-022 Req is not sampled in the cycle ack is high; back-to-back writes therefore have a spacing of at least 2 cycles.
REQ-023 Outputs row_data/addr hold their last written values between strobes.
REQ-024 Frame completion: an accepted write to row 15, panel 3 in LOCK_x pulses frame_done with that strobe and returns the FSM to IDLE on the next cycle.
REQ-025 Addresses within a lock are not checked for order; only the row 15/panel 3 write ends the frame.
REQ-026 At most one ack is high in any cycle; row_data_write_enable equals the OR of the acks.

Reset
REQ-027 While reset_n is low: FSM in IDLE, owner=00, usb_ack=diag_ack=row_data_write_enable=frame_done=0, row_data=0, row_data_row_addr=0, row_data_panel_addr=0, round-robin pointer favours USB, timeout counter=0.
REQ-028 Reset assertion mid-frame drops the lock immediately (asynchronously); no partial strobe is emitted. Release is synchronous to clk, via the existing reset synchroniser upstream.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN defined: in LOCK_x, a counter increments on every cycle without an accepted write from x and clears on each accept; reaching TIMEOUT_CYCLES returns the FSM to IDLE without frame_done.
REQ-030 ARB_TIMEOUT_EN undefined: no counter; the lock is held until frame completion or reset.

Verification
REQ-031 Reset, then a USB frame of 64 writes (panel 0..3 x row 0..15) -> 64 strobes with matching addresses and data, each 1 cycle after the req, owner=01 throughout, and frame_done on the row 15/panel 3 strobe.
REQ-032 Both sources request row0/panel0 in the same cycle after reset -> USB acked first; diag pending. After the USB frame completes, diag is granted; the next simultaneous tie goes to USB.
REQ-033 Diag requests row 5/panel 2 in IDLE -> no ack and owner stays 00 for 100 cycles; diag then changes to row 0/panel 0 -> acked and owner=10.
REQ-034 Reset asserted after 10 USB writes -> all outputs at their reset values within the same cycle; after release a diag frame start is granted.
REQ-035 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: USB locks, then goes silent -> owner returns to 00 after 16 idle cycles with no frame_done; the pending diag frame start is then granted. Without the macro the lock persists for 1000 cycles.
